// File: rtl/spi_burst_controller.sv
// SPI frame decoder: turns a command word plus data words from the SPI slave into
// register-bus reads/writes, with optional auto-incrementing burst mode.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// IDLE       | waiting for a command word; MISO shows ACK_VALUE
// CMD        | one-cycle decode of the latched command
// WR_WAIT    | waiting for the next write data word
// WR_STROBE  | one cycle; the write strobe is issued on the following cycle
// RD_FETCH   | read strobe on the bus
// RD_CAPTURE | bus read data captured into the MISO word
// RD_WAIT    | read word held on MISO until the master has clocked it out
// DONE       | rest of the frame ignored; MISO shows ACK_VALUE
module spi_burst_controller #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] ACK_VALUE  = 8'h55,
    parameter int                    CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_spi_data_rx,
    output logic [DATA_WIDTH-1:0] o_spi_data_tx,
    input  logic                  i_spi_ready,
    input  logic                  i_spi_busy,
    input  logic [DATA_WIDTH-1:0] i_data_read_bus,
    output logic [ADDR_WIDTH-1:0] o_addr_bus,
    output logic [DATA_WIDTH-1:0] o_data_write_bus,
    output logic                  o_wr_enable_bus,
    output logic                  o_rd_enable_bus,
    output logic [CNT_WIDTH-1:0]  o_word_count
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_WAIT,
        WR_STROBE,
        RD_FETCH,
        RD_CAPTURE,
        RD_WAIT,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t                state;
    logic                  write_mode;
    logic                  burst_mode;
    logic [CNT_WIDTH-1:0]  count_next;
    logic [ADDR_WIDTH-1:0] cmd_addr;

    assign count_next = (o_word_count == CNT_MAX) ? o_word_count : o_word_count + 1'b1;
    assign cmd_addr   = ADDR_WIDTH'(i_spi_data_rx[DATA_WIDTH-3:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            write_mode       <= 1'b0;
            burst_mode       <= 1'b0;
            o_addr_bus       <= '0;
            o_data_write_bus <= '0;
            o_wr_enable_bus  <= 1'b0;
            o_rd_enable_bus  <= 1'b0;
            o_spi_data_tx    <= ACK_VALUE;
            o_word_count     <= '0;
        end else begin
            o_wr_enable_bus <= 1'b0;
            o_rd_enable_bus <= 1'b0;

            // Burst writes step the address only once the strobe has gone out.
            if (o_wr_enable_bus && burst_mode)
                o_addr_bus <= o_addr_bus + 1'b1;

            case (state)
                IDLE: begin
                    o_spi_data_tx <= ACK_VALUE;
                    if (i_spi_ready) begin
                        write_mode   <= i_spi_data_rx[DATA_WIDTH-1];
                        burst_mode   <= i_spi_data_rx[DATA_WIDTH-2];
                        o_addr_bus   <= cmd_addr;
                        o_word_count <= '0;
                        state        <= CMD;
                    end
                end
                CMD: begin
                    if (!i_spi_busy) begin
                        state <= IDLE;
                    end else if (write_mode) begin
                        state <= WR_WAIT;
                    end else begin
                        o_rd_enable_bus <= 1'b1;
                        state           <= RD_FETCH;
                    end
                end
                WR_WAIT: begin
                    if (i_spi_ready) begin
                        o_data_write_bus <= i_spi_data_rx;
                        state            <= WR_STROBE;
                    end else if (!i_spi_busy) begin
                        state <= IDLE;
                    end
                end
                WR_STROBE: begin
                    // Completes even if chip select has just been released.
                    o_wr_enable_bus <= 1'b1;
                    o_word_count    <= count_next;
                    if (!i_spi_busy)
                        state <= IDLE;
                    else if (burst_mode)
                        state <= WR_WAIT;
                    else
                        state <= DONE;
                end
                RD_FETCH: begin
                    if (!i_spi_busy) begin
                        o_spi_data_tx <= ACK_VALUE;
                        state         <= IDLE;
                    end else begin
                        state <= RD_CAPTURE;
                    end
                end
                RD_CAPTURE: begin
                    if (!i_spi_busy) begin
                        o_spi_data_tx <= ACK_VALUE;
                        state         <= IDLE;
                    end else begin
                        o_spi_data_tx <= i_data_read_bus;
                        state         <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i_spi_ready) begin
                        o_word_count <= count_next;
                        if (!i_spi_busy) begin
                            o_spi_data_tx <= ACK_VALUE;
                            state         <= IDLE;
                        end else if (burst_mode) begin
                            o_addr_bus      <= o_addr_bus + 1'b1;
                            o_rd_enable_bus <= 1'b1;
                            state           <= RD_FETCH;
                        end else begin
                            o_spi_data_tx <= ACK_VALUE;
                            state         <= DONE;
                        end
                    end else if (!i_spi_busy) begin
                        o_spi_data_tx <= ACK_VALUE;
                        state         <= IDLE;
                    end
                end
                DONE: begin
                    o_spi_data_tx <= ACK_VALUE;
                    if (!i_spi_busy)
                        state <= IDLE;
                end
                default: begin
                    o_spi_data_tx <= ACK_VALUE;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_burst_controller.sv
// Bench for spi_burst_controller: an 8-bit-address instance for most frames and a
// 6-bit-address instance for the burst-read wrap frame; bus strobes are scoreboarded.
module tb_spi_burst_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx = '0;
    logic       ready = 1'b0;
    logic       busy = 1'b0;
    logic       use6 = 1'b0;
    logic       ready8, ready6;

    logic [7:0] tx8, addr8, wdata8, count8;
    logic [7:0] rdata8 = '0;
    logic       wr8, rd8;
    logic [7:0] tx6, wdata6, count6;
    logic [7:0] rdata6 = '0;
    logic [5:0] addr6;
    logic       wr6, rd6;

    logic [7:0]  mem8 [256];
    logic [7:0]  mem6 [64];
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    logic [5:0]  exp_rd6 [$];
    logic [15:0] mon_wr;
    logic [7:0]  mon_rd;
    logic [5:0]  mon_rd6;
    logic [7:0]  vals [3];
    logic [7:0]  v;

    int n_cmp = 0;
    int n_err = 0;

    assign ready8 = ready && !use6;
    assign ready6 = ready && use6;

    always #5 clk = ~clk;

    spi_burst_controller u_dut (
        .i_clk(clk), .i_rst(rst), .i_spi_data_rx(rx), .o_spi_data_tx(tx8),
        .i_spi_ready(ready8), .i_spi_busy(busy), .i_data_read_bus(rdata8),
        .o_addr_bus(addr8), .o_data_write_bus(wdata8), .o_wr_enable_bus(wr8),
        .o_rd_enable_bus(rd8), .o_word_count(count8)
    );

    spi_burst_controller #(.ADDR_WIDTH(6)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_spi_data_rx(rx), .o_spi_data_tx(tx6),
        .i_spi_ready(ready6), .i_spi_busy(busy), .i_data_read_bus(rdata6),
        .o_addr_bus(addr6), .o_data_write_bus(wdata6), .o_wr_enable_bus(wr6),
        .o_rd_enable_bus(rd6), .o_word_count(count6)
    );

    // Register-bus slave: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd8) rdata8 <= mem8[addr8];
        if (rd6) rdata6 <= mem6[addr6];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr8 || rd8) check("strobe_excl", 32'(wr8 && rd8), 32'(0));
        if (wr8) begin
            check("wr_expected", 32'(exp_wr.size() > 0), 32'(1));
            if (exp_wr.size() > 0) begin
                mon_wr = exp_wr.pop_front();
                check("wr_addr", 32'(addr8), 32'(mon_wr[15:8]));
                check("wr_data", 32'(wdata8), 32'(mon_wr[7:0]));
            end
        end
        if (rd8) begin
            check("rd_expected", 32'(exp_rd.size() > 0), 32'(1));
            if (exp_rd.size() > 0) begin
                mon_rd = exp_rd.pop_front();
                check("rd_addr", 32'(addr8), 32'(mon_rd));
            end
        end
        if (rd6) begin
            check("rd6_expected", 32'(exp_rd6.size() > 0), 32'(1));
            if (exp_rd6.size() > 0) begin
                mon_rd6 = exp_rd6.pop_front();
                check("rd6_addr", 32'(addr6), 32'(mon_rd6));
            end
        end
        if (wr6) check("wr6_unexpected", 32'(wr6), 32'(0));
    end

    // Returns 1ns after the edge that samples the ready pulse.
    task automatic send_word(input logic [7:0] w, input logic drop_busy);
        @(posedge clk); #1;
        rx = w;
        ready = 1'b1;
        if (drop_busy) busy = 1'b0;
        @(posedge clk); #1;
        ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        @(posedge clk); #1;
        busy = 1'b1;
    endtask

    task automatic frame_end();
        @(posedge clk); #1;
        busy = 1'b0;
        idle(3);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem8[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) mem6[i] = 8'($urandom);

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx8), 32'(8'h55));
        check("rst_addr", 32'(addr8), 32'(0));
        check("rst_wdata", 32'(wdata8), 32'(0));
        check("rst_wr", 32'(wr8), 32'(0));
        check("rst_rd", 32'(rd8), 32'(0));
        check("rst_count", 32'(count8), 32'(0));
        check("rst_tx6", 32'(tx6), 32'(8'h55));
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Single write, then an extra word that must be ignored
        frame_start();
        send_word(8'h85, 1'b0);
        idle(3);
        exp_wr.push_back({8'h05, 8'h3C});
        send_word(8'h3C, 1'b0);
        @(negedge clk) check("wr_lat_early", 32'(wr8), 32'(0));
        @(negedge clk) check("wr_lat_2cyc", 32'(wr8), 32'(1));
        check("wr_tx_ack", 32'(tx8), 32'(8'h55));
        idle(3);
        check("wr_count", 32'(count8), 32'(1));
        send_word(8'h99, 1'b0);
        idle(4);
        check("extra_word_count", 32'(count8), 32'(1));
        check("extra_word_tx", 32'(tx8), 32'(8'h55));
        frame_end();

        // Single read
        v = 8'hE1;
        mem8[8'h0A] = v;
        frame_start();
        exp_rd.push_back(8'h0A);
        send_word(8'h0A, 1'b0);
        repeat (3) @(negedge clk);
        check("rd_tx_early", 32'(tx8), 32'(8'h55));
        @(negedge clk) check("rd_tx_first", 32'(tx8), 32'(v));
        idle(3);
        check("rd_tx_hold", 32'(tx8), 32'(v));
        send_word(8'h00, 1'b0);
        @(negedge clk) check("rd_tx_back_ack", 32'(tx8), 32'(8'h55));
        check("rd_count", 32'(count8), 32'(1));
        frame_end();

        // Burst write across the 3F/40 boundary
        frame_start();
        send_word(8'hFE, 1'b0);
        idle(3);
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back({8'(8'h3E + i), 8'(8'h11 * (i + 1))});
            send_word(8'(8'h11 * (i + 1)), 1'b0);
            idle(4);
        end
        check("bwr_count", 32'(count8), 32'(3));
        frame_end();
        check("bwr_count_hold", 32'(count8), 32'(3));

        // Burst read wrapping the 6-bit address; last ready coincides with busy falling
        use6 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vals[i] = 8'($urandom);
            mem6[6'(6'h3F + i)] = vals[i];
            exp_rd6.push_back(6'(6'h3F + i));
        end
        frame_start();
        send_word(8'h7F, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk) check("wrap_tx0", 32'(tx6), 32'(vals[0]));
        idle(3);
        send_word(8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk) check("wrap_tx1", 32'(tx6), 32'(vals[1]));
        idle(3);
        send_word(8'hA5, 1'b0);
        repeat (2) @(negedge clk);
        @(negedge clk) check("wrap_tx2", 32'(tx6), 32'(vals[2]));
        idle(3);
        send_word(8'hA5, 1'b1);
        @(negedge clk) check("wrap_tx_ack", 32'(tx6), 32'(8'h55));
        check("wrap_count", 32'(count6), 32'(3));
        idle(4);
        use6 = 1'b0;

        // Busy falls while a read word is held on MISO
        v = 8'($urandom);
        mem8[8'h10] = v;
        frame_start();
        exp_rd.push_back(8'h10);
        send_word(8'h10, 1'b0);
        idle(5);
        check("drop_rd_tx_before", 32'(tx8), 32'(v));
        busy = 1'b0;
        @(posedge clk);
        @(negedge clk) check("drop_rd_tx_ack", 32'(tx8), 32'(8'h55));
        check("drop_rd_count", 32'(count8), 32'(0));
        idle(4);

        // Busy falls during WR_STROBE: strobe still issued, nothing after
        frame_start();
        send_word(8'hE0, 1'b0);
        idle(3);
        exp_wr.push_back({8'h20, 8'h5A});
        send_word(8'h5A, 1'b0);
        busy = 1'b0;
        @(negedge clk) check("drop_wr_early", 32'(wr8), 32'(0));
        @(negedge clk) check("drop_wr_strobe", 32'(wr8), 32'(1));
        idle(5);
        check("drop_wr_count", 32'(count8), 32'(1));
        check("drop_wr_tx", 32'(tx8), 32'(8'h55));

        // Reset in the middle of a burst write, then a fresh command
        frame_start();
        send_word(8'hC8, 1'b0);
        idle(3);
        exp_wr.push_back({8'h08, 8'h61});
        send_word(8'h61, 1'b0);
        idle(4);
        send_word(8'h77, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_wr", 32'(wr8), 32'(0));
        check("mid_rst_rd", 32'(rd8), 32'(0));
        check("mid_rst_addr", 32'(addr8), 32'(0));
        check("mid_rst_wdata", 32'(wdata8), 32'(0));
        check("mid_rst_tx", 32'(tx8), 32'(8'h55));
        check("mid_rst_count", 32'(count8), 32'(0));
        busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        frame_start();
        send_word(8'h83, 1'b0);
        idle(3);
        exp_wr.push_back({8'h03, 8'h4D});
        send_word(8'h4D, 1'b0);
        idle(4);
        check("post_rst_count", 32'(count8), 32'(1));
        frame_end();

        idle(5);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'(0));
        check("rd_queue_empty", 32'(exp_rd.size()), 32'(0));
        check("rd6_queue_empty", 32'(exp_rd6.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
